// File: rtl/font_pkg.sv
// Shared character-cell geometry and the 4x8 glyph table for the text-mode video path.
// Glyph word layout: bit (y*CH_WIDTH + x); nibble y is row y; bit 0 of a nibble is the leftmost pixel.
package font_pkg;

  localparam int CH_WIDTH   = 4;
  localparam int CH_HEIGHT  = 8;
  localparam int GLYPH_BITS = CH_WIDTH * CH_HEIGHT;

  localparam logic [GLYPH_BITS-1:0] GLYPH_BLANK   = 32'h0000_0000;
  localparam logic [GLYPH_BITS-1:0] GLYPH_SOLID   = 32'hFFFF_FFFF;
  localparam logic [GLYPH_BITS-1:0] GLYPH_CHECKER = 32'hA5A5_A5A5;

  // Glyphs are 3 pixels wide so column 3 stays a gap; row 7 is used only by descenders.
  function automatic logic [GLYPH_BITS-1:0] glyph_of(input logic [7:0] code);
    logic [GLYPH_BITS-1:0] g;
    g = GLYPH_BLANK;
    case (code)
      8'h20: g = GLYPH_BLANK;
      8'h21: g = 32'h0020_2220;
      8'h22: g = 32'h0000_0550;
      8'h23: g = 32'h0057_5750;
      8'h24: g = 32'h0036_2360;
      8'h25: g = 32'h0051_2450;
      8'h26: g = 32'h0065_2520;
      8'h27: g = 32'h0000_0220;
      8'h28: g = 32'h0042_2240;
      8'h29: g = 32'h0012_2210;
      8'h2A: g = 32'h0005_2500;
      8'h2B: g = 32'h0002_7200;
      8'h2C: g = 32'h0012_0000;
      8'h2D: g = 32'h0000_7000;
      8'h2E: g = 32'h0020_0000;
      8'h2F: g = 32'h0011_2440;
      8'h30: g = 32'h0075_5570;
      8'h31: g = 32'h0072_2320;
      8'h32: g = 32'h0071_7470;
      8'h33: g = 32'h0074_6470;
      8'h34: g = 32'h0044_7550;
      8'h35: g = 32'h0074_7170;
      8'h36: g = 32'h0075_7170;
      8'h37: g = 32'h0022_4470;
      8'h38: g = 32'h0075_7570;
      8'h39: g = 32'h0074_7570;
      8'h3A: g = 32'h0002_0200;
      8'h3B: g = 32'h0012_0200;
      8'h3C: g = 32'h0042_1240;
      8'h3D: g = 32'h0007_0700;
      8'h3E: g = 32'h0012_4210;
      8'h3F: g = 32'h0020_6470;
      8'h40: g = 32'h0061_5520;
      8'h41: g = 32'h0055_7520;
      8'h42: g = 32'h0035_3530;
      8'h43: g = 32'h0061_1160;
      8'h44: g = 32'h0035_5530;
      8'h45: g = 32'h0071_7170;
      8'h46: g = 32'h0011_7170;
      8'h47: g = 32'h0065_5160;
      8'h48: g = 32'h0055_7550;
      8'h49: g = 32'h0072_2270;
      8'h4A: g = 32'h0025_4440;
      8'h4B: g = 32'h0055_3550;
      8'h4C: g = 32'h0071_1110;
      8'h4D: g = 32'h0055_7750;
      8'h4E: g = 32'h0055_5530;
      8'h4F: g = 32'h0025_5520;
      8'h50: g = 32'h0011_3530;
      8'h51: g = 32'h0063_5520;
      8'h52: g = 32'h0055_3530;
      8'h53: g = 32'h0034_2160;
      8'h54: g = 32'h0022_2270;
      8'h55: g = 32'h0075_5550;
      8'h56: g = 32'h0025_5550;
      8'h57: g = 32'h0057_7550;
      8'h58: g = 32'h0055_2550;
      8'h59: g = 32'h0022_2550;
      8'h5A: g = 32'h0071_2470;
      8'h5B: g = 32'h0062_2260;
      8'h5C: g = 32'h0044_2110;
      8'h5D: g = 32'h0032_2230;
      8'h5E: g = 32'h0000_0520;
      8'h5F: g = 32'h0070_0000;
      8'h60: g = 32'h0000_0210;
      8'h61: g = 32'h0065_5600;
      8'h62: g = 32'h0035_5310;
      8'h63: g = 32'h0061_1600;
      8'h64: g = 32'h0065_5640;
      8'h65: g = 32'h0061_7600;
      8'h66: g = 32'h0022_7240;
      8'h67: g = 32'h3465_5600;
      8'h68: g = 32'h0055_3110;
      8'h69: g = 32'h0022_2020;
      8'h6A: g = 32'h2544_4040;
      8'h6B: g = 32'h0053_3510;
      8'h6C: g = 32'h0072_2230;
      8'h6D: g = 32'h0055_7300;
      8'h6E: g = 32'h0055_5300;
      8'h6F: g = 32'h0025_5200;
      8'h70: g = 32'h1135_5300;
      8'h71: g = 32'h4465_5600;
      8'h72: g = 32'h0011_1600;
      8'h73: g = 32'h0034_1600;
      8'h74: g = 32'h0042_2720;
      8'h75: g = 32'h0065_5500;
      8'h76: g = 32'h0025_5500;
      8'h77: g = 32'h0077_5500;
      8'h78: g = 32'h0052_2500;
      8'h79: g = 32'h3465_5500;
      8'h7A: g = 32'h0073_6700;
      8'h7B: g = 32'h0062_1260;
      8'h7C: g = 32'h0222_2222;
      8'h7D: g = 32'h0032_4230;
      8'h7E: g = 32'h0000_6300;
      8'hFE: g = GLYPH_CHECKER;
      8'hFF: g = GLYPH_SOLID;
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/font_rom_if.sv
// Character-code to glyph lookup bus between the character memory and the font ROM.
// No valid/ready: a lookup is issued every clock, and gfx reflects the ch sampled on the previous edge.
interface font_rom_if;
  import font_pkg::*;

  logic [7:0]            ch;
  logic [GLYPH_BITS-1:0] gfx;

  modport master (output ch, input gfx);
  modport slave  (input ch, output gfx);

endinterface

// File: rtl/font_rom.sv
// Character-generator ROM: combinational glyph decode of ch followed by one async-clear output register.
module font_rom #(
  parameter int CH_WIDTH  = 4,
  parameter int CH_HEIGHT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  font_rom_if.slave   bus
);
  import font_pkg::*;

  logic [CH_WIDTH*CH_HEIGHT-1:0] gfx_d;
  logic [CH_WIDTH*CH_HEIGHT-1:0] gfx_q;

  always_comb begin
    gfx_d = glyph_of(bus.ch);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gfx_q <= GLYPH_BLANK;
    end else begin
      gfx_q <= gfx_d;
    end
  end

  assign bus.gfx = gfx_q;

endmodule

// File: tb/tb_font_rom.sv
// Bench for font_rom: directed reset/latency/bit-order cases, full code sweeps and random streaming.
module tb_font_rom;
  import font_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  font_rom_if bus ();

  font_rom dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Reference glyph built from the code-map rules; printable glyph art comes from the golden table.
  function automatic logic [31:0] ref_glyph(input logic [7:0] c);
    logic [31:0] g;
    g = 32'h0;
    if (c == 8'hFF) begin
      g = 32'hFFFF_FFFF;
    end else if (c == 8'hFE) begin
      for (int y = 0; y < 8; y++)
        for (int x = 0; x < 4; x++)
          g[y*4 + x] = ((x + y) % 2 == 0);
    end else if (c == 8'h7C) begin
      for (int y = 0; y < 7; y++) g[y*4 + 1] = 1'b1;
    end else if (c > 8'h20 && c < 8'h7F) begin
      g = glyph_of(c);
    end
    return g;
  endfunction

  // Called just after a rising edge: output must hold until the next edge, then show the new glyph.
  task automatic drive(input logic [7:0] c, input string tag);
    logic [31:0] e;
    bus.ch = c;
    exp_q.push_back(ref_glyph(c));
    #1;
    check_eq({tag, "_hold"}, bus.gfx, last_exp);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq(tag, bus.gfx, e);
    last_exp = e;
  endtask

  initial begin
    logic [7:0] c;
    logic       desc;
    rst_n    = 1'b0;
    bus.ch   = 8'hFF;
    last_exp = 32'h0;

    // Reset asserted, no clock edge yet, and held low across an edge.
    #2;
    check_eq("rst_no_edge", bus.gfx, 32'h0);
    @(posedge clk);
    #1;
    check_eq("rst_held", bus.gfx, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_release", bus.gfx, 32'hFFFF_FFFF);
    last_exp = 32'hFFFF_FFFF;

    // Latency and back-to-back specials.
    drive(8'h20, "lat_space");
    drive(8'h7C, "lat_bar");
    check_eq("bar_const", bus.gfx, 32'h0222_2222);
    drive(8'hFE, "lat_checker");
    check_eq("checker_const", bus.gfx, 32'hA5A5_A5A5);
    check_eq("bit0",  {31'b0, bus.gfx[0]},  32'd1);
    check_eq("bit1",  {31'b0, bus.gfx[1]},  32'd0);
    check_eq("bit4",  {31'b0, bus.gfx[4]},  32'd0);
    check_eq("bit5",  {31'b0, bus.gfx[5]},  32'd1);
    check_eq("bit31", {31'b0, bus.gfx[31]}, 32'd1);
    drive(8'hFF, "lat_solid");
    check_eq("solid_const", bus.gfx, 32'hFFFF_FFFF);
    drive(8'hFF, "hold_same");

    // Async reset pulse between edges while streaming 0xFF.
    rst_n = 1'b0;
    #1;
    check_eq("midrst_low", bus.gfx, 32'h0);
    #1;
    rst_n = 1'b1;
    #1;
    check_eq("midrst_released", bus.gfx, 32'h0);
    @(posedge clk);
    #1;
    check_eq("midrst_next_edge", bus.gfx, 32'hFFFF_FFFF);
    last_exp = 32'hFFFF_FFFF;

    // Unmapped codes decode blank.
    for (int i = 8'h00; i <= 8'hFD; i++) begin
      if (i < 8'h20 || i > 8'h7E) begin
        drive(8'(i), "unmapped");
        check_eq("unmapped_zero", bus.gfx, 32'h0);
      end
    end

    // Printable sweep: golden table, nonzero, row 7 only for descenders.
    for (int i = 8'h21; i <= 8'h7E; i++) begin
      c = 8'(i);
      drive(c, "printable");
      desc = (c == "g" || c == "j" || c == "p" || c == "q" || c == "y");
      check_eq("printable_nz", {31'b0, |bus.gfx}, 32'd1);
      check_eq("row7_desc", {31'b0, |bus.gfx[31:28]}, {31'b0, desc});
    end

    // Random stream with occasional repeated codes.
    for (int i = 0; i < 300; i++) begin
      c = 8'($urandom_range(0, 255));
      drive(c, "random");
      if ($urandom_range(0, 3) == 0) drive(c, "random_repeat");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
